axi4_burst_writer_p: RTL and testbench

Parametrised single-clock successor to the pixel AXI4 writer. It buffers a valid/ready word stream, already synchronised into the memory-clock domain, in an internal FIFO. It drains the FIFO to DDR as AXI4 INCR write bursts at a per-frame base address. It adds what the first generation lacks: configurable width, burst and depth; partial-burst flush on frame end; frame wrap; and BRESP error tracking.

---
 rtl/axiw_pkg.sv | 31 +++
 rtl/axiw_sync_fifo.sv | 53 +++++
 rtl/axi4_burst_writer_p.sv | 225 ++++++++++++++++++++++
 tb/tb_axi4_burst_writer_p.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axiw_pkg.sv
// Shared types and constants for the AXI4 burst writer.
// Holds the FSM state encoding, fixed AXI attribute codes and the
// AWSIZE helper derived from the data width.
package axiw_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } axiw_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] CACHE_BUF  = 4'b0011;

    // AWSIZE is log2 of the bytes per beat.
    function automatic logic [2:0] awsize_f(input int data_w);
        logic [2:0] s;
        int         bytes;
        s     = 3'd0;
        bytes = data_w / 8;
        for (int i = 0; i < 8; i++) begin
            if ((1 << i) == bytes) begin
                s = 3'(i);
            end
        end
        return s;
    endfunction

endpackage

// File: rtl/axiw_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy output.
// The head word is visible on rd_data whenever the FIFO is not empty;
// rd_en consumes it. Storage is a plain array so it maps to RAM.
module axiw_sync_fifo #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_reg;
    logic [PTR_W:0]    rd_ptr_reg;
    logic              empty;

    // Extra pointer bit distinguishes full from empty.
    assign level   = wr_ptr_reg - rd_ptr_reg;
    assign full    = (level == (PTR_W+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr_reg[PTR_W-1:0]];

    // Storage write; no reset so the array stays a RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !full) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
        end
    end

    // Pointer update; simultaneous read and write keep the level constant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_en && !full) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_en && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_burst_writer_p.sv
// Stream-to-AXI4 burst writer: buffers stream words and writes them as
// INCR bursts at a per-frame base plus a running offset, flushing a
// partial burst on frame end and tracking BRESP errors.
// Optional build macro AXIW_PINGPONG_EN adds a second frame base
// (frame_base_b) selected alternately on each frame_ack, shown on buf_sel.
module axi4_burst_writer_p
    import axiw_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int BURST_LEN   = 16,
    parameter int FIFO_DEPTH  = 64,
    parameter int FRAME_BYTES = 614400
) (
    input  logic                         clk_100Mhz,
    input  logic                         rst_n,
    input  logic [DATA_W-1:0]            s_data,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic                         frame_done,
    input  logic [ADDR_W-1:0]            frame_base,
`ifdef AXIW_PINGPONG_EN
    input  logic [ADDR_W-1:0]            frame_base_b,
    output logic                         buf_sel,
`endif
    output logic [ADDR_W-1:0]            AWADDR,
    output logic [7:0]                   AWLEN,
    output logic [2:0]                   AWSIZE,
    output logic [1:0]                   AWBURST,
    output logic [3:0]                   AWCACHE,
    output logic [2:0]                   AWPROT,
    output logic                         AWVALID,
    input  logic                         AWREADY,
    output logic [DATA_W-1:0]            WDATA,
    output logic [DATA_W/8-1:0]          WSTRB,
    output logic                         WLAST,
    output logic                         WVALID,
    input  logic                         WREADY,
    input  logic [1:0]                   BRESP,
    input  logic                         BVALID,
    output logic                         BREADY,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         frame_ack,
    output logic                         err_sticky,
    output logic [1:0]                   state
);

    localparam int         LVL_W    = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] AWSIZE_C = awsize_f(DATA_W);

    axiw_state_t       state_reg, state_next;
    logic [LVL_W-1:0]  level_w, level_next;
    logic [DATA_W-1:0] head_w;
    logic              full_w;
    logic              push, pop;
    logic              issue, frame_ack_c, last_beat;
    logic              aw_active, w_active;
    logic [8:0]        n_issue, n_reg, beat_reg;
    logic [ADDR_W-1:0] base_sel, base_lat_reg, awaddr_issue, awaddr_reg;
    logic [ADDR_W-1:0] offset_reg, offset_sum;
    logic              flush_pending_reg;
    logic [LVL_W-1:0]  flush_cnt_reg;
    logic              err_reg;
    logic              run_reg;

    axiw_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_100Mhz),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (head_w),
        .full    (full_w),
        .level   (level_w)
    );

    // run_reg keeps the stream stalled while reset is held.
    assign s_ready    = run_reg && !full_w && !flush_pending_reg;
    assign push       = s_valid && s_ready;
    assign aw_active  = (state_reg == ST_ADDR);
    assign w_active   = (state_reg == ST_DATA);
    assign pop        = w_active && WREADY;
    assign last_beat  = (beat_reg == n_reg - 9'd1);
    assign level_next = level_w + LVL_W'(push) - LVL_W'(pop);
    assign offset_sum = offset_reg + (ADDR_W'(n_reg) << AWSIZE_C);

`ifdef AXIW_PINGPONG_EN
    logic buf_sel_reg;
    assign base_sel = buf_sel_reg ? frame_base_b : frame_base;
    assign buf_sel  = buf_sel_reg;
`else
    assign base_sel = frame_base;
`endif

    // A new frame's base is taken when its first burst is issued.
    assign awaddr_issue = ((offset_reg == '0) ? base_sel : base_lat_reg) + offset_reg;

    // Burst length: full bursts normally, the remainder while flushing.
    always_comb begin
        n_issue = 9'(BURST_LEN);
        if (flush_pending_reg && (int'(flush_cnt_reg) < BURST_LEN)) begin
            n_issue = 9'(flush_cnt_reg);
        end
    end

    // Next-state logic with the issue and frame-ack strobes.
    always_comb begin
        state_next  = state_reg;
        issue       = 1'b0;
        frame_ack_c = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (flush_pending_reg && (flush_cnt_reg == '0)) begin
                    frame_ack_c = 1'b1;
                end else if ((int'(level_w) >= BURST_LEN) ||
                             (flush_pending_reg && (flush_cnt_reg != '0))) begin
                    issue      = 1'b1;
                    state_next = ST_ADDR;
                end
            end
            ST_ADDR: if (AWREADY) state_next = ST_DATA;
            ST_DATA: if (WREADY && last_beat) state_next = ST_RESP;
            ST_RESP: if (BVALID) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // Capture address, length and frame base when a burst is issued.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            n_reg        <= '0;
            awaddr_reg   <= '0;
            base_lat_reg <= '0;
        end else if (issue) begin
            n_reg      <= n_issue;
            awaddr_reg <= awaddr_issue;
            if (offset_reg == '0) begin
                base_lat_reg <= base_sel;
            end
        end
    end

    // Beat counter within the current burst.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n)     beat_reg <= '0;
        else if (issue) beat_reg <= '0;
        else if (pop)   beat_reg <= beat_reg + 9'd1;
    end

    // Frame offset advances per acknowledged burst, wraps at frame size.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            offset_reg <= '0;
        end else if (frame_ack_c) begin
            offset_reg <= '0;
        end else if ((state_reg == ST_RESP) && BVALID) begin
            offset_reg <= (offset_sum >= ADDR_W'(FRAME_BYTES)) ? '0 : offset_sum;
        end
    end

    // Flush tracking. flush_cnt follows every pop during a flush so it
    // always equals the words still to write, even when frame_done lands
    // in the middle of a burst.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            flush_pending_reg <= 1'b0;
            flush_cnt_reg     <= '0;
        end else if (frame_done && !flush_pending_reg) begin
            flush_pending_reg <= 1'b1;
            flush_cnt_reg     <= level_next;
        end else if (frame_ack_c) begin
            flush_pending_reg <= 1'b0;
        end else if (flush_pending_reg && pop) begin
            flush_cnt_reg <= flush_cnt_reg - 1'b1;
        end
    end

    // Sticky error flag for any non-OKAY write response.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) err_reg <= 1'b0;
        else if ((state_reg == ST_RESP) && BVALID && (BRESP != RESP_OKAY)) err_reg <= 1'b1;
    end

    // Enables the stream once reset has been released.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) run_reg <= 1'b0;
        else        run_reg <= 1'b1;
    end

`ifdef AXIW_PINGPONG_EN
    // Alternate between the two frame buffers at each frame end.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n)           buf_sel_reg <= 1'b0;
        else if (frame_ack_c) buf_sel_reg <= !buf_sel_reg;
    end
`endif

    // Channel outputs are forced to zero outside their active state.
    assign AWVALID    = aw_active;
    assign AWADDR     = aw_active ? awaddr_reg : '0;
    assign AWLEN      = aw_active ? 8'(n_reg - 9'd1) : 8'd0;
    assign AWSIZE     = aw_active ? AWSIZE_C : 3'd0;
    assign AWBURST    = aw_active ? BURST_INCR : 2'd0;
    assign AWCACHE    = aw_active ? CACHE_BUF : 4'd0;
    assign AWPROT     = 3'd0;
    assign WVALID     = w_active;
    assign WDATA      = w_active ? head_w : '0;
    assign WSTRB      = {(DATA_W/8){w_active}};
    assign WLAST      = w_active && last_beat;
    assign BREADY     = (state_reg == ST_RESP);
    assign fifo_level = level_w;
    assign frame_ack  = frame_ack_c;
    assign err_sticky = err_reg;
    assign state      = state_reg;

endmodule

// File: tb/tb_axi4_burst_writer_p.sv
// Bench for axi4_burst_writer_p: table of burst transactions plus
// hand-written stall, backpressure, empty-frame and reset sequences.
// Write data is checked against a scoreboard filled from accepted pushes.
module tb_axi4_burst_writer_p;

    localparam int ADDR_W = 32, DATA_W = 64, BURST_LEN = 16;
    localparam int FIFO_DEPTH = 64, FRAME_BYTES = 614400;

    logic              clk_100Mhz = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic              frame_done = 1'b0;
    logic [ADDR_W-1:0] frame_base = '0;
    logic [ADDR_W-1:0] AWADDR;
    logic [7:0]        AWLEN;
    logic [2:0]        AWSIZE;
    logic [1:0]        AWBURST;
    logic [3:0]        AWCACHE;
    logic [2:0]        AWPROT;
    logic              AWVALID;
    logic              AWREADY = 1'b1;
    logic [DATA_W-1:0] WDATA;
    logic [7:0]        WSTRB;
    logic              WLAST, WVALID;
    logic              WREADY = 1'b1;
    logic [1:0]        BRESP;
    logic              BVALID, BREADY;
    logic [6:0]        fifo_level;
    logic              frame_ack, err_sticky;
    logic [1:0]        state;
    logic [1:0]        bresp_val = 2'b00;
    logic              wready_mode = 1'b0;
`ifdef AXIW_PINGPONG_EN
    logic              buf_sel;
`endif

    // Write response returned in the first RESP cycle.
    assign BVALID = BREADY;
    assign BRESP  = bresp_val;

    axi4_burst_writer_p #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN),
        .FIFO_DEPTH(FIFO_DEPTH), .FRAME_BYTES(FRAME_BYTES)
    ) dut (
        .clk_100Mhz(clk_100Mhz), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .frame_done(frame_done), .frame_base(frame_base),
`ifdef AXIW_PINGPONG_EN
        .frame_base_b(frame_base), .buf_sel(buf_sel),
`endif
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .fifo_level(fifo_level), .frame_ack(frame_ack), .err_sticky(err_sticky),
        .state(state)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;

    typedef struct {
        int          nwords;
        bit          flush;
        logic [31:0] base;
        logic [1:0]  bresp;
        logic [31:0] exp_addr;
        logic [7:0]  exp_len;
        bit          exp_err;
    } vec_t;

    aw_t         aw_q[$];
    logic [63:0] data_q[$];
    int vectors = 0, miscompares = 0;
    int cyc = 0, b_count = 0, ack_count = 0, b_cyc = 0, ack_cyc = 0;
    int mon_beat = 0;
    bit pushed_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever #5 clk_100Mhz = ~clk_100Mhz;

    // WREADY either held high or toggled every cycle.
    initial forever begin
        @(posedge clk_100Mhz);
        #1;
        WREADY = wready_mode ? !WREADY : 1'b1;
    end

    // Monitor: fills the scoreboard from pushes, checks AW/W beats and holds.
    initial begin
        bit          in_burst, prev_aw_stall, prev_w_stall, prev_wlast;
        logic [31:0] prev_awaddr;
        logic [7:0]  prev_awlen, cur_len;
        logic [63:0] prev_wdata, exp_d;
        aw_t         a;
        in_burst = 0; prev_aw_stall = 0; prev_w_stall = 0; prev_wlast = 0;
        prev_awaddr = '0; prev_awlen = '0; cur_len = '0; prev_wdata = '0;
        forever begin
            @(negedge clk_100Mhz);
            cyc++;
            if (!rst_n) begin
                in_burst = 0; mon_beat = 0; prev_aw_stall = 0; prev_w_stall = 0;
            end else begin
                if (s_valid && s_ready) data_q.push_back(s_data);
                if (prev_aw_stall) begin
                    chk("aw_hold_addr", 64'(AWADDR), 64'(prev_awaddr));
                    chk("aw_hold_len", 64'(AWLEN), 64'(prev_awlen));
                end
                if (prev_w_stall) begin
                    chk("w_hold_data", WDATA, prev_wdata);
                    chk("w_hold_last", 64'(WLAST), 64'(prev_wlast));
                end
                if (AWVALID && AWREADY) begin
                    chk("aw_expected", 64'(aw_q.size() != 0), 64'(1));
                    if (aw_q.size() != 0) begin
                        a = aw_q.pop_front();
                        chk("awaddr", 64'(AWADDR), 64'(a.addr));
                        chk("awlen", 64'(AWLEN), 64'(a.len));
                        chk("aw_attr", 64'({AWSIZE, AWBURST, AWCACHE, AWPROT}),
                            64'({3'd3, 2'b01, 4'b0011, 3'd0}));
                    end
                    cur_len = AWLEN; in_burst = 1; mon_beat = 0;
                end
                if (WVALID && WREADY) begin
                    chk("w_in_burst", 64'(in_burst), 64'(1));
                    chk("wstrb", 64'(WSTRB), 64'(8'hFF));
                    chk("w_sb_avail", 64'(data_q.size() != 0), 64'(1));
                    if (data_q.size() != 0) begin
                        exp_d = data_q.pop_front();
                        chk("wdata", WDATA, exp_d);
                    end
                    chk("wlast", 64'(WLAST), 64'(mon_beat == int'(cur_len)));
                    mon_beat++;
                    if (WLAST) in_burst = 0;
                end
                if (BVALID && BREADY) begin b_count++; b_cyc = cyc; end
                if (frame_ack) begin ack_count++; ack_cyc = cyc; end
                prev_aw_stall = AWVALID && !AWREADY;
                prev_awaddr = AWADDR; prev_awlen = AWLEN;
                prev_w_stall = WVALID && !WREADY;
                prev_wdata = WDATA; prev_wlast = WLAST;
            end
        end
    end

    task automatic step();
        @(posedge clk_100Mhz);
        #1;
    endtask

    // Push n words first, first+1, ...; bounded wait on s_ready per word.
    task automatic push_words(input int n, input logic [63:0] first);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            s_data = first + 64'(i);
            s_valid = 1'b1;
            @(negedge clk_100Mhz);
            while (!s_ready && t < 2000) begin @(negedge clk_100Mhz); t++; end
            if (!s_ready) begin
                chk("push_timeout", 64'(s_ready), 64'(1));
                break;
            end
            @(posedge clk_100Mhz);
            #1;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_b(input int target);
        int t = 0;
        while (b_count < target && t < 4000) begin @(negedge clk_100Mhz); t++; end
        chk("b_wait", 64'(b_count >= target), 64'(1));
    endtask

    task automatic wait_ack(input int target);
        int t = 0;
        while (ack_count < target && t < 100) begin @(negedge clk_100Mhz); t++; end
        chk("ack_wait", 64'(ack_count >= target), 64'(1));
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        step();
        frame_done = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_aw"}, 64'({AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWCACHE, AWPROT}), 64'(0));
        chk({tag, "_wdata"}, WDATA, 64'(0));
        chk({tag, "_w"}, 64'({WVALID, WLAST, WSTRB, BREADY}), 64'(0));
        chk({tag, "_misc"}, 64'({s_ready, fifo_level, frame_ack, err_sticky, state}), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   nb, na;
        vt[0] = '{16, 1'b0, 32'h1000_0000, 2'b00, 32'h1000_0000, 8'd15, 1'b0};
        vt[1] = '{16, 1'b0, 32'h1000_0000, 2'b00, 32'h1000_0080, 8'd15, 1'b0};
        vt[2] = '{ 5, 1'b1, 32'h1000_0000, 2'b00, 32'h1000_0100, 8'd4,  1'b0};
        vt[3] = '{16, 1'b0, 32'h2000_0000, 2'b00, 32'h2000_0000, 8'd15, 1'b0};
        vt[4] = '{ 3, 1'b1, 32'h2000_0000, 2'b10, 32'h2000_0080, 8'd2,  1'b1};
        vt[5] = '{16, 1'b0, 32'h3000_0000, 2'b00, 32'h3000_0000, 8'd15, 1'b1};

        // Reset state
        repeat (3) @(posedge clk_100Mhz);
        #1;
        check_zero_outputs("reset");
        rst_n = 1'b1;
        step(); step();

        // Table-driven bursts
        for (int i = 0; i < 6; i++) begin
            frame_base = vt[i].base;
            bresp_val  = vt[i].bresp;
            aw_q.push_back('{vt[i].exp_addr, vt[i].exp_len});
            nb = b_count;
            na = ack_count;
            push_words(vt[i].nwords, 64'(i * 256 + 1));
            if (vt[i].flush) begin
                pulse_done();
            end else if (vt[i].nwords == BURST_LEN) begin
                @(negedge clk_100Mhz);
                chk("latency_c1", 64'(AWVALID), 64'(0));
                @(negedge clk_100Mhz);
                chk("latency_c2", 64'(AWVALID), 64'(1));
            end
            wait_b(nb + 1);
            @(negedge clk_100Mhz);
            if (vt[i].flush) begin
                wait_ack(na + 1);
                chk("ack_after_b", 64'(ack_cyc - b_cyc), 64'(1));
            end else begin
                chk("no_ack", 64'(ack_count), 64'(na));
            end
            chk("err_sticky", 64'(err_sticky), 64'(vt[i].exp_err));
            chk("level_empty", 64'(fifo_level), 64'(0));
            step();
        end
        bresp_val = 2'b00;

        // WREADY toggling for one burst
        wready_mode = 1'b1;
        aw_q.push_back('{32'h3000_0080, 8'd15});
        nb = b_count;
        push_words(16, 64'h1000);
        wait_b(nb + 1);
        @(negedge clk_100Mhz);
        wready_mode = 1'b0;
        chk("toggle_err_kept", 64'(err_sticky), 64'(1));
        step();

        // AWREADY held low while 70 words are offered
        AWREADY = 1'b0;
        for (int k = 0; k < 4; k++) aw_q.push_back('{32'h3000_0100 + 32'(k * 128), 8'd15});
        nb = b_count;
        pushed_done = 1'b0;
        fork
            begin
                push_words(70, 64'h2000);
                pushed_done = 1'b1;
            end
        join_none
        repeat (80) @(negedge clk_100Mhz);
        chk("bp_level", 64'(fifo_level), 64'(64));
        chk("bp_s_ready", 64'(s_ready), 64'(0));
        chk("bp_awvalid", 64'(AWVALID), 64'(1));
        chk("bp_awaddr", 64'(AWADDR), 64'(32'h3000_0100));
        step();
        AWREADY = 1'b1;
        for (int t = 0; t < 3000 && !pushed_done; t++) @(negedge clk_100Mhz);
        chk("bp_pushed", 64'(pushed_done), 64'(1));
        wait_b(nb + 4);
        @(negedge clk_100Mhz);
        chk("bp_remainder", 64'(fifo_level), 64'(6));
        aw_q.push_back('{32'h3000_0300, 8'd5});
        na = ack_count;
        step();
        pulse_done();
        wait_b(nb + 5);
        @(negedge clk_100Mhz);
        wait_ack(na + 1);
        chk("bp_ack_after_b", 64'(ack_cyc - b_cyc), 64'(1));

        // Empty frame: frame_ack one cycle after frame_done
        step();
        frame_done = 1'b1;
        @(negedge clk_100Mhz);
        chk("empty_ack_c0", 64'(frame_ack), 64'(0));
        step();
        frame_done = 1'b0;
        @(negedge clk_100Mhz);
        chk("empty_ack_c1", 64'(frame_ack), 64'(1));
        @(negedge clk_100Mhz);
        chk("empty_ack_c2", 64'(frame_ack), 64'(0));

        // Reset during beat 7 of a burst
        step();
        frame_base = 32'h3800_0000;
        aw_q.push_back('{32'h3800_0000, 8'd15});
        push_words(16, 64'h3000);
        for (int t = 0; t < 200 && mon_beat < 6; t++) @(negedge clk_100Mhz);
        chk("mid_burst_reached", 64'(mon_beat >= 6), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        aw_q.delete();
        data_q.delete();
        repeat (2) @(posedge clk_100Mhz);
        #1;
        rst_n = 1'b1;
        step(); step();
        chk("rst_err_cleared", 64'(err_sticky), 64'(0));
        frame_base = 32'h4000_0000;
        aw_q.push_back('{32'h4000_0000, 8'd15});
        nb = b_count;
        push_words(16, 64'h4000);
        wait_b(nb + 1);
        @(negedge clk_100Mhz);
        chk("post_rst_level", 64'(fifo_level), 64'(0));

        chk("aw_q_drained", 64'(aw_q.size()), 64'(0));
        chk("data_q_drained", 64'(data_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
